change_return_ctrl: RTL and testbench

- Parametrised successor to the vending machine's coin-return timer. Handles N coin denominations and a configurable inactivity timeout.
- Replaces the single-shot return mask with a sequential greedy dispenser: one coin per valid/ready handshake.
- Sits between the transaction datapath (which owns current_total) and the coin-output mechanism.
- Reports each dispensed coin's value so the datapath decrements its total.

---
 rtl/change_return_pkg.sv | 37 +++
 rtl/change_return_ctrl_if.sv | 13 +
 rtl/greedy_coin_select.sv | 40 ++++
 rtl/change_return_ctrl.sv | 157 +++++++++++++++
 tb/tb_change_return_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/change_return_pkg.sv
// Shared types and helpers for the change-return controller.
// Optional inventory tracking is enabled by defining CHANGE_RETURN_INVENTORY_EN.
package change_return_pkg;

    localparam int CR_NUM_COINS_DEF   = 3;
    localparam int CR_TOTAL_BITS_DEF  = 31;
    localparam int CR_WAIT_CYCLES_DEF = 100;
    localparam int CR_WAIT_BITS_DEF   = 32;

    // Upper bounds the slice helper can address
    localparam int CR_MAX_COINS = 8;
    localparam int CR_MAX_BITS  = 32;
    localparam int CR_MAX_VEC   = CR_MAX_COINS * CR_MAX_BITS;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        LOAD   = 3'd2,
        RETURN = 3'd3,
        DONE   = 3'd4
    } cr_state_t;

    // Extract denomination k from a packed value vector of 'bits'-wide fields
    function automatic logic [CR_MAX_BITS-1:0] coin_slice(
        input logic [CR_MAX_VEC-1:0] vals,
        input int unsigned           k,
        input int unsigned           bits
    );
        logic [CR_MAX_VEC-1:0]  shifted;
        logic [CR_MAX_BITS-1:0] mask;
        shifted = vals >> (k * bits);
        mask    = (bits >= CR_MAX_BITS) ? '1
                : ((CR_MAX_BITS'(1) << bits) - CR_MAX_BITS'(1));
        return shifted[CR_MAX_BITS-1:0] & mask;
    endfunction

endpackage

// File: rtl/change_return_ctrl_if.sv
// Coin dispense handshake between the controller (master) and the coin-output mechanism (slave).
interface change_return_ctrl_if #(
    parameter int NUM_COINS  = 3,
    parameter int TOTAL_BITS = 31
);
    logic                  return_valid;
    logic [NUM_COINS-1:0]  return_coin;
    logic                  return_ready;
    logic [TOTAL_BITS-1:0] dec_value;

    modport master (output return_valid, return_coin, dec_value, input return_ready);
    modport slave  (input return_valid, return_coin, dec_value, output return_ready);
endinterface

// File: rtl/greedy_coin_select.sv
// Combinational greedy search: largest available denomination not exceeding rem.
module greedy_coin_select
    import change_return_pkg::*;
#(
    parameter int NUM_COINS  = CR_NUM_COINS_DEF,
    parameter int TOTAL_BITS = CR_TOTAL_BITS_DEF
) (
    input  logic [TOTAL_BITS-1:0]           rem,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_values,
    input  logic [NUM_COINS-1:0]            coin_avail,
    output logic                            found,
    output logic [NUM_COINS-1:0]            onehot,
    output logic [TOTAL_BITS-1:0]           value
);

    logic [TOTAL_BITS-1:0] val_arr [NUM_COINS];
    logic [NUM_COINS-1:0]  fits;

    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_slice
            assign val_arr[gi] = TOTAL_BITS'(coin_slice(CR_MAX_VEC'(coin_values), gi, TOTAL_BITS));
            assign fits[gi]    = coin_avail[gi] && (val_arr[gi] <= rem);
        end
    endgenerate

    // Ascending scan so the highest qualifying index overwrites lower ones
    always_comb begin
        found  = 1'b0;
        onehot = '0;
        value  = '0;
        for (int k = 0; k < NUM_COINS; k++) begin
            if (fits[k]) begin
                found  = 1'b1;
                onehot = NUM_COINS'(1) << k;
                value  = val_arr[k];
            end
        end
    end

endmodule

// File: rtl/change_return_ctrl.sv
// Change-return controller: inactivity timer plus sequential greedy coin dispenser.
// Define CHANGE_RETURN_INVENTORY_EN to add per-denomination stock limits (i_coin_stock).
module change_return_ctrl
    import change_return_pkg::*;
#(
    parameter int NUM_COINS   = CR_NUM_COINS_DEF,
    parameter int TOTAL_BITS  = CR_TOTAL_BITS_DEF,
    parameter int WAIT_CYCLES = CR_WAIT_CYCLES_DEF,
    parameter int WAIT_BITS   = CR_WAIT_BITS_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_values,
    input  logic [NUM_COINS-1:0]            i_input_coin,
    input  logic                            i_item_out,
    input  logic                            i_trigger_return,
    input  logic [TOTAL_BITS-1:0]           i_current_total,
`ifdef CHANGE_RETURN_INVENTORY_EN
    input  logic [NUM_COINS*8-1:0]          i_coin_stock,
`endif
    change_return_ctrl_if.master            ret_if,
    output logic                            o_busy,
    output logic                            o_done,
    output logic [TOTAL_BITS-1:0]           o_residual,
    output logic [WAIT_BITS-1:0]            o_wait_time
);

    localparam logic [WAIT_BITS-1:0] WAIT_RELOAD = WAIT_BITS'(WAIT_CYCLES);

    cr_state_t             state_q, state_d;
    logic [WAIT_BITS-1:0]  timer_q, timer_d;
    logic [TOTAL_BITS-1:0] rem_q, rem_d;

    logic                  strobe;
    logic                  total_nz;
    logic                  accept;
    logic                  sel_found;
    logic [NUM_COINS-1:0]  sel_onehot;
    logic [TOTAL_BITS-1:0] sel_value;
    logic [NUM_COINS-1:0]  coin_avail;

    assign strobe   = (|i_input_coin) || i_item_out;
    assign total_nz = (i_current_total != '0);
    assign accept   = (state_q == RETURN) && sel_found && ret_if.return_ready;

`ifdef CHANGE_RETURN_INVENTORY_EN
    logic [7:0] used_q [NUM_COINS];
    logic [7:0] used_d [NUM_COINS];

    // A denomination is usable while its stock exceeds what this return already used
    generate
        for (genvar gi = 0; gi < NUM_COINS; gi++) begin : g_avail
            assign coin_avail[gi] = (i_coin_stock[gi*8 +: 8] > used_q[gi]);
        end
    endgenerate

    // Used counts restart at LOAD and count accepted coins per denomination
    always_comb begin
        for (int k = 0; k < NUM_COINS; k++) begin
            used_d[k] = used_q[k];
            if (state_q == LOAD) begin
                used_d[k] = '0;
            end else if (accept && sel_onehot[k]) begin
                used_d[k] = used_q[k] + 8'd1;
            end
        end
    end

    // Used-count registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_COINS; k++) used_q[k] <= '0;
        end else begin
            used_q <= used_d;
        end
    end
`else
    assign coin_avail = '1;
`endif

    greedy_coin_select #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_select (
        .rem         (rem_q),
        .coin_values (i_coin_values),
        .coin_avail  (coin_avail),
        .found       (sel_found),
        .onehot      (sel_onehot),
        .value       (sel_value)
    );

    // Next-state, timer and remaining-balance logic
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                timer_d = WAIT_RELOAD;
                if (i_trigger_return && total_nz) state_d = LOAD;
                else if (total_nz || strobe)      state_d = COUNT;
            end
            COUNT: begin
                // Trigger beats reload; activity reload beats timeout
                if (i_trigger_return) begin
                    state_d = LOAD;
                    timer_d = (timer_q != '0) ? timer_q - WAIT_BITS'(1) : '0;
                end else if (strobe) begin
                    timer_d = WAIT_RELOAD;
                end else if (timer_q == '0) begin
                    state_d = LOAD;
                end else if (!total_nz) begin
                    state_d = IDLE;
                    timer_d = WAIT_RELOAD;
                end else begin
                    timer_d = timer_q - WAIT_BITS'(1);
                end
            end
            LOAD: begin
                rem_d   = i_current_total;
                state_d = RETURN;
            end
            RETURN: begin
                if (!sel_found)                 state_d = DONE;
                else if (ret_if.return_ready)   rem_d   = rem_q - sel_value;
            end
            DONE: begin
                timer_d = WAIT_RELOAD;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, timer and balance registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= WAIT_RELOAD;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
        end
    end

    assign ret_if.return_valid = (state_q == RETURN) && sel_found;
    assign ret_if.return_coin  = ret_if.return_valid ? sel_onehot : '0;
    assign ret_if.dec_value    = accept ? sel_value : '0;
    assign o_busy              = (state_q == RETURN);
    assign o_done              = (state_q == DONE);
    assign o_residual          = o_done ? rem_q : '0;
    assign o_wait_time         = timer_q;

endmodule

// File: tb/tb_change_return_ctrl.sv
// Self-checking bench for change_return_ctrl: vector table, hand sequences, randomized run vs model.
module tb_change_return_ctrl;

    localparam int NC = 3;
    localparam int TB = 31;
    localparam int WC = 5;
    localparam int WB = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_COUNT = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_RET   = 3;
    localparam int PH_DONE  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NC*TB-1:0]  coin_values;
    logic [NC-1:0]     input_coin;
    logic              item_out;
    logic              trig;
    logic [TB-1:0]     total;
    logic              busy;
    logic              done;
    logic [TB-1:0]     residual;
    logic [WB-1:0]     wait_time;
`ifdef CHANGE_RETURN_INVENTORY_EN
    logic [NC*8-1:0]   coin_stock;
`endif

    always #5 clk = ~clk;

    change_return_ctrl_if #(.NUM_COINS(NC), .TOTAL_BITS(TB)) rif ();

    change_return_ctrl #(
        .NUM_COINS   (NC),
        .TOTAL_BITS  (TB),
        .WAIT_CYCLES (WC),
        .WAIT_BITS   (WB)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_coin_values    (coin_values),
        .i_input_coin     (input_coin),
        .i_item_out       (item_out),
        .i_trigger_return (trig),
        .i_current_total  (total),
`ifdef CHANGE_RETURN_INVENTORY_EN
        .i_coin_stock     (coin_stock),
`endif
        .ret_if           (rif),
        .o_busy           (busy),
        .o_done           (done),
        .o_residual       (residual),
        .o_wait_time      (wait_time)
    );

    int n_cmp = 0;
    int n_bad = 0;

    longint vals [NC];

    // Reference model: phase, timer, and the whole coin list planned at LOAD
    int     m_phase;
    int     m_timer;
    longint m_resid;
    int     m_q [$];
    int     m_stock [NC];

    // Observations from the latest cycle
    int              obs_wait;
    logic            obs_busy;
    logic            obs_valid;
    int              obs_acc;
    int              obs_done;
    longint          obs_resid;
    logic [NC-1:0]   obs_coins [$];

    typedef struct {
        longint tot;
        bit     toggle;
        int     exp_coins;
        longint exp_resid;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_timer = WC;
        m_resid = 0;
        m_q.delete();
    endtask

    // Plan the full greedy dispense with plain arithmetic
    task automatic model_plan(input longint tot);
        longint r;
        int     st [NC];
        r  = tot;
        st = m_stock;
        m_q.delete();
        for (int k = NC - 1; k >= 0; k--) begin
            while (r >= vals[k] && st[k] > 0) begin
                m_q.push_back(k);
                r = r - vals[k];
                st[k]--;
            end
        end
        m_resid = r;
    endtask

    task automatic model_step();
        bit strobe;
        strobe = (input_coin != '0) || item_out;
        if (!reset_n) begin
            model_reset();
            return;
        end
        case (m_phase)
            PH_IDLE: begin
                m_timer = WC;
                if (trig && total != 0)           m_phase = PH_LOAD;
                else if (total != 0 || strobe)    m_phase = PH_COUNT;
            end
            PH_COUNT: begin
                if (trig) begin
                    m_phase = PH_LOAD;
                    if (m_timer > 0) m_timer--;
                end else if (strobe) begin
                    m_timer = WC;
                end else if (m_timer == 0) begin
                    m_phase = PH_LOAD;
                end else if (total == 0) begin
                    m_phase = PH_IDLE;
                    m_timer = WC;
                end else begin
                    m_timer--;
                end
            end
            PH_LOAD: begin
                model_plan(longint'(total));
                m_phase = PH_RET;
            end
            PH_RET: begin
                if (m_q.size() == 0)  m_phase = PH_DONE;
                else if (rif.return_ready) void'(m_q.pop_front());
            end
            default: begin
                m_phase = PH_IDLE;
                m_timer = WC;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic            ev;
        logic [NC-1:0]   ecoin;
        longint          edec;
        ev    = (m_phase == PH_RET) && (m_q.size() > 0);
        ecoin = ev ? (NC'(1) << m_q[0]) : '0;
        edec  = (ev && rif.return_ready) ? vals[m_q[0]] : 0;
        chk("valid",    64'(rif.return_valid), 64'(ev));
        chk("coin",     64'(rif.return_coin),  64'(ecoin));
        chk("dec_value",64'(rif.dec_value),    64'(edec));
        chk("busy",     64'(busy),             64'(m_phase == PH_RET));
        chk("done",     64'(done),             64'(m_phase == PH_DONE));
        chk("residual", 64'(residual),         64'((m_phase == PH_DONE) ? m_resid : 0));
        chk("wait_time",64'(wait_time),        64'(m_timer));
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        obs_wait  = int'(wait_time);
        obs_busy  = busy;
        obs_valid = rif.return_valid;
        if (rif.return_valid && rif.return_ready) begin
            obs_acc++;
            obs_coins.push_back(rif.return_coin);
        end
        if (done) begin
            obs_done++;
            obs_resid = longint'(residual);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Start a return from IDLE and run it to o_done within a cycle budget
    task automatic run_return(input longint tot, input bit toggle);
        int start_done;
        int budget;
        start_done = obs_done;
        obs_acc = 0;
        obs_coins.delete();
        total = TB'(tot);
        trig  = 1'b1;
        rif.return_ready = 1'b1;
        cycle();
        trig = 1'b0;
        budget = 0;
        while (obs_done == start_done && budget < 60) begin
            rif.return_ready = toggle ? ~rif.return_ready : 1'b1;
            cycle();
            budget++;
        end
        chk("return_timeout", 64'(obs_done == start_done), 64'(0));
        total = '0;
        rif.return_ready = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic set_stock_all(input int n);
        for (int k = 0; k < NC; k++) m_stock[k] = n;
`ifdef CHANGE_RETURN_INVENTORY_EN
        for (int k = 0; k < NC; k++) coin_stock[k*8 +: 8] = 8'(m_stock[k]);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int exp_wait [6];

        vals[0] = 100;
        vals[1] = 500;
        vals[2] = 1000;
        for (int k = 0; k < NC; k++) coin_values[k*TB +: TB] = TB'(vals[k]);
`ifdef CHANGE_RETURN_INVENTORY_EN
        set_stock_all(255);
`else
        for (int k = 0; k < NC; k++) m_stock[k] = 1 << 30;
`endif

        vecs[0] = '{1600, 1'b0, 3, 0};
        vecs[1] = '{650,  1'b1, 2, 50};
        vecs[2] = '{99,   1'b0, 0, 99};
        vecs[3] = '{100,  1'b1, 1, 0};
        vecs[4] = '{1099, 1'b0, 1, 99};
        vecs[5] = '{2700, 1'b1, 5, 0};
        vecs[6] = '{1000, 1'b0, 1, 0};

        obs_acc = 0; obs_done = 0; obs_resid = 0;
        reset_n = 1'b0; input_coin = '0; item_out = 1'b0; trig = 1'b0; total = '0;
        rif.return_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        cycle();
        chk("reset_wait", 64'(obs_wait), 64'(WC));
        chk("reset_busy", 64'(obs_busy), 64'(0));
        $display("reset check: wait_time=%0d busy=%0d", obs_wait, obs_busy);

        // Table-driven returns
        for (int i = 0; i < 7; i++) begin
            run_return(vecs[i].tot, vecs[i].toggle);
            chk("vec_coins", 64'(obs_acc), 64'(vecs[i].exp_coins));
            chk("vec_resid", 64'(obs_resid), 64'(vecs[i].exp_resid));
            $display("vector %0d: total=%0d toggle=%0d coins=%0d residual=%0d",
                     i, vecs[i].tot, vecs[i].toggle, obs_acc, obs_resid);
            if (i == 0 && obs_coins.size() == 3) begin
                chk("order_0", 64'(obs_coins[0]), 64'(3'b100));
                chk("order_1", 64'(obs_coins[1]), 64'(3'b010));
                chk("order_2", 64'(obs_coins[2]), 64'(3'b001));
            end
        end

        // Inactivity timeout: 5..0 then three 100 coins
        exp_wait = '{5, 4, 3, 2, 1, 0};
        obs_acc = 0;
        d0 = obs_done;
        total = TB'(300);
        rif.return_ready = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("timeout_wait", 64'(obs_wait), 64'(exp_wait[i]));
        end
        for (int b = 0; b < 20 && obs_done == d0; b++) cycle();
        chk("timeout_done", 64'(obs_done - d0), 64'(1));
        chk("timeout_coins", 64'(obs_acc), 64'(3));
        chk("timeout_resid", 64'(obs_resid), 64'(0));
        $display("timeout return: coins=%0d residual=%0d", obs_acc, obs_resid);
        total = '0; rif.return_ready = 1'b0;
        cycle(); cycle();

        // Strobe at wait_time=1 reloads the timer and no return starts
        exp_wait = '{5, 5, 4, 3, 2, 1};
        total = TB'(300);
        cycle();
        for (int i = 1; i < 6; i++) begin
            if (i == 5) input_coin = 3'b001;
            cycle();
            chk("strobe_wait", 64'(obs_wait), 64'(exp_wait[i]));
        end
        input_coin = '0;
        cycle();
        chk("strobe_reload", 64'(obs_wait), 64'(WC));
        chk("strobe_nobusy", 64'(obs_busy), 64'(0));
        $display("strobe reload: wait_time=%0d busy=%0d", obs_wait, obs_busy);
        total = '0;
        cycle(); cycle();

        // Reset after the first of three accepts
        d0 = obs_done;
        total = TB'(1600); rif.return_ready = 1'b1; trig = 1'b1;
        cycle();
        trig = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1; total = '0; rif.return_ready = 1'b0;
        cycle();
        chk("rst_valid", 64'(obs_valid), 64'(0));
        chk("rst_busy",  64'(obs_busy),  64'(0));
        chk("rst_wait",  64'(obs_wait),  64'(WC));
        repeat (4) cycle();
        chk("rst_no_done", 64'(obs_done - d0), 64'(0));
        $display("mid-return reset: busy=%0d done_pulses=%0d", obs_busy, obs_done - d0);

`ifdef CHANGE_RETURN_INVENTORY_EN
        // Stock {5,0,1}: 1000 then five 100 coins
        m_stock[0] = 5; m_stock[1] = 0; m_stock[2] = 1;
        for (int k = 0; k < NC; k++) coin_stock[k*8 +: 8] = 8'(m_stock[k]);
        run_return(1500, 1'b0);
        chk("inv_coins", 64'(obs_acc), 64'(6));
        chk("inv_resid", 64'(obs_resid), 64'(0));
        if (obs_coins.size() == 6) begin
            chk("inv_first", 64'(obs_coins[0]), 64'(3'b100));
            chk("inv_last",  64'(obs_coins[5]), 64'(3'b001));
        end
        $display("inventory return: coins=%0d residual=%0d", obs_acc, obs_resid);
        for (int k = 0; k < NC; k++) m_stock[k] = int'($urandom_range(0, 3));
        for (int k = 0; k < NC; k++) coin_stock[k*8 +: 8] = 8'(m_stock[k]);
`endif

        // Randomized run against the model
        d0 = obs_done;
        for (int i = 0; i < 1500; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: total = '0;
                    1: total = TB'(650);
                    2: total = TB'(1600);
                    3: total = TB'(2700);
                    4: total = TB'(50);
                    default: total = TB'($urandom_range(0, 4999));
                endcase
            end
            input_coin = ($urandom_range(0, 19) == 0) ? NC'($urandom_range(1, 7)) : '0;
            item_out   = ($urandom_range(0, 24) == 0);
            trig       = ($urandom_range(0, 11) == 0);
            rif.return_ready = $urandom_range(0, 1) != 0;
            cycle();
        end
        reset_n = 1'b1;
        $display("random run: %0d returns completed", obs_done - d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
